antilog_converter: RTL and testbench

ANTILOG_CONVERTER -- requirements
Module: antilog_converter

---
 rtl/antilog_converter.sv | 117 +++++++++++
 tb/tb_antilog_converter.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/antilog_converter.sv
// -----------------------------------------------------------------------------
// antilog_converter
//
// Converts a log-domain operand back to the linear domain:
//   product = ({1'b1, OPs_sum} << log_sum) >> (WIDTH-1), fraction truncated.
// A set zero_in flag forces the product to 0.
//
// Two-stage valid/ready pipeline:
//   S1 registers the mantissa with its hidden one, coarse-shifted by a
//      multiple of 8 taken from log_sum[LOG2_WIDTH:3]. It also registers the
//      fine shift amount and the zero flag.
//   S2 applies the fine shift log_sum[2:0], right-aligns the result by
//      WIDTH-1 and applies the zero mask.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operand presented
//   in_ready   operand accepted this cycle (combinational from out_ready)
//   OPs_sum    summed mantissa, fraction bits only (WIDTH-1 bits)
//   log_sum    summed characteristic (LOG2_WIDTH+1 bits)
//   zero_in    one multiplicand was zero; product is forced to 0
//   out_valid  product valid
//   out_ready  downstream accepts the product
//   product    linear-domain product (2*WIDTH bits)
// -----------------------------------------------------------------------------
module antilog_converter #(
  parameter int LOG2_WIDTH = 4,
  parameter int WIDTH      = 2**LOG2_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-2:0]      OPs_sum,
  input  logic [LOG2_WIDTH:0]   log_sum,
  input  logic                  zero_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [2*WIDTH-1:0]    product
);

  // Wide enough that the largest mantissa shifted by the largest log_sum
  // keeps every integer bit.
  localparam int SHIFT_W = WIDTH + 2**(LOG2_WIDTH+1) - 1;

  logic                  s1_valid;
  logic [SHIFT_W-1:0]    s1_coarse;
  logic [2:0]            s1_fine;
  logic                  s1_zero;

  logic                  s2_valid;
  logic [2*WIDTH-1:0]    s2_product;

  logic                  s2_advance;
  logic                  in_fire;

  logic [SHIFT_W-1:0]    mant_ext;
  logic [LOG2_WIDTH:0]   coarse_amt;
  logic [SHIFT_W-1:0]    coarse_shifted;
  logic [SHIFT_W-1:0]    fine_shifted;
  logic [2*WIDTH-1:0]    product_next;
  logic [WIDTH-2:0]      discarded_frac_unused;

  // S2 moves whenever its content is consumed or it holds nothing; S1 drains
  // into S2 under the same condition, so in_ready follows it directly.
  assign s2_advance = out_ready | ~s2_valid;
  assign in_ready   = ~s1_valid | s2_advance;
  assign in_fire    = in_valid & in_ready;

  // Coarse shift: log_sum with its three low bits cleared is a multiple of 8.
  assign mant_ext       = {{(SHIFT_W-WIDTH){1'b0}}, 1'b1, OPs_sum};
  assign coarse_amt     = {log_sum[LOG2_WIDTH:3], 3'b000};
  assign coarse_shifted = mant_ext << coarse_amt;

  // Fine shift, then drop the WIDTH-1 fraction bits (floor).
  assign fine_shifted          = s1_coarse << s1_fine;
  assign discarded_frac_unused = fine_shifted[WIDTH-2:0];
  assign product_next          = s1_zero ? '0 : fine_shifted[WIDTH-1 +: 2*WIDTH];

  // S1 valid bit follows in_valid whenever S1 is free to move; its data only
  // loads on an actual transfer so a bubble never overwrites held data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_coarse <= '0;
      s1_fine   <= '0;
      s1_zero   <= 1'b0;
    end else begin
      if (in_ready) begin
        s1_valid <= in_valid;
      end
      if (in_fire) begin
        s1_coarse <= coarse_shifted;
        s1_fine   <= log_sum[2:0];
        s1_zero   <= zero_in;
      end
    end
  end

  // S2 holds while a valid product waits on out_ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid   <= 1'b0;
      s2_product <= '0;
    end else if (s2_advance) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_product <= product_next;
      end
    end
  end

  assign out_valid = s2_valid;
  assign product   = s2_product;

endmodule

// File: tb/tb_antilog_converter.sv
// -----------------------------------------------------------------------------
// tb_antilog_converter
//
// Self-checking bench for antilog_converter (WIDTH=16). Directed vectors come
// from a table, followed by hand-written stall and reset sequences and a
// randomized run against a scoreboard fed by an arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_antilog_converter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [14:0] OPs_sum;
  logic [4:0]  log_sum;
  logic        zero_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] product;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [4:0]  log_sum;
    logic [14:0] ops;
    logic        zero;
    logic [31:0] expected;
  } vector_t;

  vector_t vectors[11];

  logic [31:0] exp_q[$];

  antilog_converter #(.LOG2_WIDTH(4), .WIDTH(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .OPs_sum   (OPs_sum),
    .log_sum   (log_sum),
    .zero_in   (zero_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product)
  );

  always #5 clk = ~clk;

  // Linear value of 1.OPs_sum * 2**log_sum, floored to an integer.
  function automatic logic [31:0] refProduct(input logic [4:0] l,
                                             input logic [14:0] ops,
                                             input logic z);
    longint unsigned mant;
    longint unsigned full;
    if (z) return 32'd0;
    mant = 64'd32768 + longint'(ops);
    full = mant * (64'd1 << l);
    return 32'(full / 64'd32768);
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Called on a falling edge; presents one operand with out_ready high and
  // follows it through the pipeline, returning on a falling edge.
  task automatic applyStimulus(input vector_t v);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    log_sum   = v.log_sum;
    OPs_sum   = v.ops;
    zero_in   = v.zero;
    #1;
    checkOutput("vec_in_ready", in_ready, 1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    checkOutput("vec_latency_early", out_valid, 0);
    @(negedge clk);
    #1;
    checkOutput("vec_out_valid", out_valid, 1);
    checkOutput("vec_product", product, v.expected);
    @(negedge clk);
    #1;
    checkOutput("vec_drained", out_valid, 0);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] held;
    logic        hold_pending;
    int          budget;

    vectors[0]  = '{5'd3,  15'h0000, 1'b0, 32'd8};
    vectors[1]  = '{5'd2,  15'h4000, 1'b0, 32'd6};
    vectors[2]  = '{5'd0,  15'h7FFF, 1'b0, 32'd1};
    vectors[3]  = '{5'd31, 15'h7FFF, 1'b0, 32'hFFFF0000};
    vectors[4]  = '{5'd31, 15'h7FFF, 1'b1, 32'd0};
    vectors[5]  = '{5'd0,  15'h0000, 1'b0, 32'd1};
    vectors[6]  = '{5'd7,  15'h7FFF, 1'b0, 32'h000000FF};
    vectors[7]  = '{5'd8,  15'h2000, 1'b0, 32'h00000140};
    vectors[8]  = '{5'd15, 15'h0000, 1'b0, 32'h00008000};
    vectors[9]  = '{5'd16, 15'h0001, 1'b0, 32'h00010002};
    vectors[10] = '{5'd24, 15'h0000, 1'b0, 32'h01000000};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    OPs_sum   = '0;
    log_sum   = '0;
    zero_in   = 1'b0;

    repeat (2) @(negedge clk);
    #1;
    checkOutput("reset_out_valid", out_valid, 0);
    checkOutput("reset_product", product, 0);
    checkOutput("reset_in_ready", in_ready, 1);

    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 11; i++) begin
      applyStimulus(vectors[i]);
    end

    // Back-to-back inputs into a stalled output.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    zero_in   = 1'b0;
    OPs_sum   = '0;
    log_sum   = 5'd1;
    #1;
    checkOutput("stall_in_ready_1", in_ready, 1);
    @(negedge clk);
    log_sum = 5'd2;
    #1;
    checkOutput("stall_in_ready_2", in_ready, 1);
    @(negedge clk);
    log_sum = 5'd3;
    #1;
    checkOutput("stall_in_ready_full", in_ready, 0);
    checkOutput("stall_out_valid", out_valid, 1);
    checkOutput("stall_product", product, 2);
    @(negedge clk);
    #1;
    checkOutput("stall_hold_in_ready", in_ready, 0);
    checkOutput("stall_hold_product", product, 2);
    out_ready = 1'b1;
    #1;
    checkOutput("release_in_ready", in_ready, 1);
    checkOutput("release_product_0", product, 2);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    checkOutput("release_out_valid_1", out_valid, 1);
    checkOutput("release_product_1", product, 4);
    @(negedge clk);
    #1;
    checkOutput("release_out_valid_2", out_valid, 1);
    checkOutput("release_product_2", product, 8);
    @(negedge clk);
    #1;
    checkOutput("release_empty", out_valid, 0);

    // Reset asserted while both stages hold data.
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    log_sum   = 5'd5;
    @(negedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    checkOutput("full_out_valid", out_valid, 1);
    checkOutput("full_in_ready", in_ready, 0);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("async_rst_out_valid", out_valid, 0);
    checkOutput("async_rst_product", product, 0);
    checkOutput("async_rst_in_ready", in_ready, 1);
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checkOutput("post_rst_no_stale", out_valid, 0);
      @(negedge clk);
    end
    applyStimulus(vectors[1]);

    // Randomized traffic against the scoreboard.
    hold_pending = 1'b0;
    held         = '0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      log_sum   = 5'($urandom);
      OPs_sum   = 15'($urandom);
      zero_in   = ($urandom_range(0, 7) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (hold_pending) begin
        checkOutput("rand_hold_valid", out_valid, 1);
        checkOutput("rand_hold_product", product, held);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) checkOutput("rand_unexpected_output", 1, 0);
        else checkOutput("rand_product", product, exp_q.pop_front());
      end
      hold_pending = out_valid && !out_ready;
      held         = product;
      if (in_valid && in_ready) exp_q.push_back(refProduct(log_sum, OPs_sum, zero_in));
      @(negedge clk);
    end

    in_valid  = 1'b0;
    out_ready = 1'b1;
    budget    = 0;
    while ((exp_q.size() != 0 || out_valid) && budget < 20) begin
      #1;
      if (out_valid) begin
        if (exp_q.size() == 0) checkOutput("drain_unexpected_output", 1, 0);
        else checkOutput("drain_product", product, exp_q.pop_front());
      end
      budget++;
      @(negedge clk);
    end
    checkOutput("drain_remaining", 64'(exp_q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
